mdu_sched: RTL and testbench

Multi-cycle multiply/divide scheduler for the five-stage pipeline. It accepts MDU operations issued from the E stage and holds the HI/LO architectural registers. It models the fixed multiply/divide latency with a countdown, and raises a stall request back to the D-stage stall logic while any HI/LO-touching instruction in D must wait. It sits beside the ALU in E and merges into the existing stall OR alongside the register-hazard stall.

---
 rtl/mdu_sched_pkg.sv | 45 ++++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu_sched.sv | 103 ++++++++++
 tb/tb_mdu_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared MDU opcode constants and decode helpers for mdu_sched and the Controller.
// MDU_MADD_EN adds the multiply-accumulate opcodes; they need a 4-bit op field.
package mdu_sched_pkg;

`ifdef MDU_MADD_EN
   localparam int MDU_OP_W = 4;
`else
   localparam int MDU_OP_W = 3;
`endif

   localparam logic [MDU_OP_W-1:0] MDU_MULT  = MDU_OP_W'(0);
   localparam logic [MDU_OP_W-1:0] MDU_MULTU = MDU_OP_W'(1);
   localparam logic [MDU_OP_W-1:0] MDU_DIV   = MDU_OP_W'(2);
   localparam logic [MDU_OP_W-1:0] MDU_DIVU  = MDU_OP_W'(3);
   localparam logic [MDU_OP_W-1:0] MDU_MTHI  = MDU_OP_W'(4);
   localparam logic [MDU_OP_W-1:0] MDU_MTLO  = MDU_OP_W'(5);
`ifdef MDU_MADD_EN
   localparam logic [MDU_OP_W-1:0] MDU_MADD  = MDU_OP_W'(8);
   localparam logic [MDU_OP_W-1:0] MDU_MADDU = MDU_OP_W'(9);
   localparam logic [MDU_OP_W-1:0] MDU_MSUB  = MDU_OP_W'(10);
   localparam logic [MDU_OP_W-1:0] MDU_MSUBU = MDU_OP_W'(11);
`endif

   function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
`ifdef MDU_MADD_EN
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
             (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
      return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
   endfunction

   function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
`ifdef MDU_MADD_EN
      return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
`else
      return (op == MDU_MULT) || (op == MDU_DIV);
`endif
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit MDU result generator: {hi,lo} for multiply, {rem,quot} for divide.
// Under MDU_MADD_EN it also folds the product into the current {hi,lo}.
module mdu_arith
   import mdu_sched_pkg::*;
(
   input  logic [MDU_OP_W-1:0] op,
   input  logic [31:0]         a,
   input  logic [31:0]         b,
   input  logic [31:0]         hi,
   input  logic [31:0]         lo,
   output logic [63:0]         result,
   output logic                div_zero
);

   logic        sgn;
   logic [63:0] prod;
   logic [31:0] ua, ub, ub_safe, uq, ur, q, r;

   always_comb begin
      sgn = op_is_signed(op);
      // Low 64 bits of the sign/zero-extended product are correct for both signednesses.
      prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};

      // Divide on magnitudes; the overflow case 0x80000000/-1 falls out as 0x80000000 rem 0.
      ua       = (sgn && a[31]) ? 32'(-a) : a;
      ub       = (sgn && b[31]) ? 32'(-b) : b;
      div_zero = op_is_div(op) && (b == 32'd0);
      ub_safe  = (b == 32'd0) ? 32'd1 : ub;
      uq       = ua / ub_safe;
      ur       = ua % ub_safe;
      q        = (sgn && (a[31] ^ b[31])) ? 32'(-uq) : uq;
      r        = (sgn && a[31]) ? 32'(-ur) : ur;

      result = prod;
      if (op_is_div(op))
         result = {r, q};
`ifdef MDU_MADD_EN
      else if ((op == MDU_MADD) || (op == MDU_MADDU))
         result = {hi, lo} + prod;
      else if ((op == MDU_MSUB) || (op == MDU_MSUBU))
         result = {hi, lo} - prod;
`endif
   end

`ifndef MDU_MADD_EN
   logic unused_acc;
   assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: owns HI/LO, models op latency with a countdown,
// and requests a D-stage stall while a HI/LO consumer must wait. Option: MDU_MADD_EN.
module mdu_sched
   import mdu_sched_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [MDU_OP_W-1:0] op,
   input  logic [31:0]         a,
   input  logic [31:0]         b,
   input  logic                md_d,
   output logic [31:0]         hi,
   output logic [31:0]         lo,
   output logic                busy,
   output logic                stall_req
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [63:0]   res, res_n, arith_res;
   logic          wr, wr_n, div_zero;
   logic [31:0]   hi_n, lo_n;

   mdu_arith u_arith (
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .result   (arith_res),
      .div_zero (div_zero)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      res_n   = res;
      wr_n    = wr;
      hi_n    = hi;
      lo_n    = lo;
      case (state)
         IDLE: begin
            if (start) begin
               if (op_is_mul(op) || op_is_div(op)) begin
                  res_n   = arith_res;
                  wr_n    = !div_zero;
                  cnt_n   = op_is_div(op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                  state_n = RUN;
               end else if (op == MDU_MTHI) begin
                  hi_n = a;
               end else if (op == MDU_MTLO) begin
                  lo_n = a;
               end
            end
         end
         RUN: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               if (wr)
                  {hi_n, lo_n} = res;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         res   <= '0;
         wr    <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         res   <= res_n;
         wr    <= wr_n;
         hi    <= hi_n;
         lo    <= lo_n;
      end
   end

   assign busy      = (state == RUN);
   assign stall_req = md_d & (start | busy);

   // The D-stage stall should make this impossible; the op is dropped if it happens.
   a_no_start_busy : assert property (@(posedge clk) disable iff (reset) !(start && busy))
      else $error("mdu_sched: start while busy, op ignored");

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, arithmetic corners, HI/LO moves, stall and async reset.
module tb_mdu_sched;
   import mdu_sched_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [MDU_OP_W-1:0] op = '0;
   logic [31:0]         a = '0;
   logic [31:0]         b = '0;
   logic                md_d = 1'b0;
   logic [31:0]         hi, lo;
   logic                busy, stall_req;

   int checks = 0;
   int errors = 0;

   mdu_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .md_d      (md_d),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op for a single cycle, then count busy cycles (bounded) and check stall.
   task automatic issue(input string tag, input logic [MDU_OP_W-1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic m, input int lat);
      int  n;
      bit  done;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y; md_d = m;
      #4;
      chk({tag, "_stall_c0"}, 64'(stall_req), 64'(m));
      chk({tag, "_busy_c0"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      done = 1'b0;
      for (int i = 0; i < lat + 4 && !done; i++) begin
         #4;
         if (busy) begin
            n++;
            chk({tag, "_stall_busy"}, 64'(stall_req), 64'(m));
            @(posedge clk); #1;
         end else begin
            done = 1'b1;
         end
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
      chk({tag, "_stall_after"}, 64'(stall_req), 64'd0);
      md_d = 1'b0;
   endtask

   initial begin
      logic [MDU_OP_W-1:0] ill;
      ill = MDU_OP_W'(6);

      md_d = 1'b1;
      #2;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      #10 reset = 1'b0; md_d = 1'b0;

      issue("mult_neg", MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 5);
      chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
      chk("mult_neg_lo", 64'(lo), 64'hFFFFFFFA);

      issue("mult_nostall", MDU_MULT, 32'd7, 32'd9, 1'b0, 5);
      chk("mult_pos_hi", 64'(hi), 64'h0);
      chk("mult_pos_lo", 64'(lo), 64'h3F);

      issue("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 5);
      chk("multu_hi", 64'(hi), 64'h1);
      chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

      issue("divu", MDU_DIVU, 32'd17, 32'd5, 1'b1, 10);
      chk("divu_hi", 64'(hi), 64'd2);
      chk("divu_lo", 64'(lo), 64'd3);

      issue("div_neg", MDU_DIV, 32'hFFFFFFEF, 32'd5, 1'b0, 10);
      chk("div_neg_hi", 64'(hi), 64'hFFFFFFFE);
      chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);

      issue("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
      chk("div_ovf_hi", 64'(hi), 64'h0);
      chk("div_ovf_lo", 64'(lo), 64'h80000000);

      issue("mtlo", MDU_MTLO, 32'h00005555, 32'd0, 1'b0, 0);
      chk("mtlo_lo", 64'(lo), 64'h5555);
      chk("mtlo_hi", 64'(hi), 64'h0);

      issue("mthi", MDU_MTHI, 32'h12345678, 32'd0, 1'b0, 0);
      chk("mthi_hi", 64'(hi), 64'h12345678);
      chk("mthi_lo", 64'(lo), 64'h5555);

      issue("mthi_aaaa", MDU_MTHI, 32'h0000AAAA, 32'd0, 1'b0, 0);
      issue("div_zero", MDU_DIV, 32'd9, 32'd0, 1'b1, 10);
      chk("div_zero_hi", 64'(hi), 64'hAAAA);
      chk("div_zero_lo", 64'(lo), 64'h5555);

      issue("illegal", ill, 32'hDEADBEEF, 32'd1, 1'b0, 0);
      chk("illegal_hi", 64'(hi), 64'hAAAA);
      chk("illegal_lo", 64'(lo), 64'h5555);

      // Async reset in cycle 3 of a DIV
      @(posedge clk); #1;
      start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7; md_d = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_hi", 64'(hi), 64'd0);
      chk("async_rst_lo", 64'(lo), 64'd0);
      chk("async_rst_stall", 64'(stall_req), 64'd0);
      #20 reset = 1'b0;
      repeat (14) @(posedge clk);
      #4;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_hi", 64'(hi), 64'd0);
      chk("post_rst_lo", 64'(lo), 64'd0);
      chk("post_rst_stall", 64'(stall_req), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
